// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle core: opcodes, ALU codes, mux selects, FSM states.
// Used by the controller, ALU and datapath so every block agrees on the same values.
package multi_cycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RD1    = 2'b10;

    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_MEM_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // How the ALU operation is chosen in a given state.
    localparam logic [1:0] ALU_CLASS_ADD   = 2'b00;
    localparam logic [1:0] ALU_CLASS_SUB   = 2'b01;
    localparam logic [1:0] ALU_CLASS_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE_R,
        S_EXECUTE_I,
        S_ALU_WB,
        S_BEQ,
        S_JAL
    } state_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU operation decode: fixed add/sub, or funct3/funct7_5 driven in the execute states.
// funct_illegal flags a funct3 the ALU does not implement; the op falls back to add.
module alu_decoder
    import multi_cycle_controller_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 3
) (
    input  logic [1:0]              alu_class,
    input  logic [2:0]              funct3,
    input  logic                    funct7_5,
    input  logic                    r_type,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    funct_illegal
);

    logic [2:0] code;

    always_comb begin
        code          = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_class)
            ALU_CLASS_SUB: code = ALU_SUB;
            ALU_CLASS_FUNCT: begin
                case (funct3)
                    F3_ADD:  code = (r_type && funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  code = ALU_SLT;
                    F3_OR:   code = ALU_OR;
                    F3_AND:  code = ALU_AND;
                    default: begin
                        code          = ALU_ADD;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_op = ALU_OP_WIDTH'(code);

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencing the multi-cycle datapath; write enables are held off while rst is high
// so the asynchronous return to FETCH never produces a spurious write.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic                    funct7_5,
    input  logic                    zero,
    output logic                    pc_write,
    output logic                    adr_src,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    reg_write,
    output logic [1:0]              result_src,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              imm_src,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    illegal_instr
);

    state_t     state, next_state;
    logic       pc_update, branch;
    logic       ir_write_int, mem_write_int, reg_write_int;
    logic       decode_illegal, check_funct, funct_illegal;
    logic [1:0] alu_class;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state     = state;
        pc_update      = 1'b0;
        branch         = 1'b0;
        ir_write_int   = 1'b0;
        mem_write_int  = 1'b0;
        reg_write_int  = 1'b0;
        decode_illegal = 1'b0;
        check_funct    = 1'b0;
        adr_src        = ADR_PC;
        result_src     = RES_ALU_OUT;
        alu_src_a      = SRC_A_PC;
        alu_src_b      = SRC_B_RD2;
        alu_class      = ALU_CLASS_ADD;
        case (state)
            S_FETCH: begin
                ir_write_int = 1'b1;
                pc_update    = 1'b1;
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALU_RESULT;
                next_state   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
                    OP_RTYPE:          next_state = S_EXECUTE_R;
                    OP_ITYPE:          next_state = S_EXECUTE_I;
                    OP_BRANCH:         next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    default: begin
                        next_state     = S_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_IMM;
                next_state = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                adr_src    = ADR_RESULT;
                next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src    = RES_MEM_DATA;
                reg_write_int = 1'b1;
                next_state    = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src       = ADR_RESULT;
                mem_write_int = 1'b1;
                next_state    = S_FETCH;
            end
            S_EXECUTE_R: begin
                alu_src_a   = SRC_A_RD1;
                alu_src_b   = SRC_B_RD2;
                alu_class   = ALU_CLASS_FUNCT;
                check_funct = 1'b1;
                next_state  = S_ALU_WB;
            end
            S_EXECUTE_I: begin
                alu_src_a   = SRC_A_RD1;
                alu_src_b   = SRC_B_IMM;
                alu_class   = ALU_CLASS_FUNCT;
                check_funct = 1'b1;
                next_state  = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_int = 1'b1;
                next_state    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_RD2;
                alu_class  = ALU_CLASS_SUB;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                pc_update  = 1'b1;
                next_state = S_ALU_WB;
            end
            default: next_state = S_FETCH;
        endcase
    end

    alu_decoder #(.ALU_OP_WIDTH(ALU_OP_WIDTH)) u_alu_decoder (
        .alu_class     (alu_class),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .r_type        (state == S_EXECUTE_R),
        .alu_op        (alu_op),
        .funct_illegal (funct_illegal)
    );

    assign pc_write      = ~rst & (pc_update | (branch & zero));
    assign ir_write      = ~rst & ir_write_int;
    assign mem_write     = ~rst & mem_write_int;
    assign reg_write     = ~rst & reg_write_int;
    assign illegal_instr = ~rst & (decode_illegal | (check_funct & funct_illegal));
    assign imm_src       = imm_src_of(opcode);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: each instruction is expanded into its list of expected
// per-cycle control words, then replayed against the DUT with random fields and zero flag.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_op;

    int vectors     = 0;
    int miscompares = 0;

    multi_cycle_controller #(.ALU_OP_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_op(alu_op), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcu, br, adr, memw, irw, regw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] op;
    } step_t;

    step_t plan[$];

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    function automatic logic [1:0] ref_imm(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BQ) return 2'b10;
        if (o == JL) return 2'b11;
        return 2'b00;
    endfunction

    // Expand one instruction into the control word of every cycle it occupies.
    task automatic build_plan(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        step_t s;
        plan.delete();
        s = '0; s.irw = 1; s.pcu = 1; s.sb = 2'b10; s.rs = 2'b10;
        plan.push_back(s);
        s = '0; s.sa = 2'b01; s.sb = 2'b01;
        if (!(o inside {LW, SW, RT, IT, BQ, JL})) begin
            s.ill = 1;
            plan.push_back(s);
            return;
        end
        plan.push_back(s);
        if (o == LW || o == SW) begin
            s = '0; s.sa = 2'b10; s.sb = 2'b01;
            plan.push_back(s);
            s = '0; s.adr = 1;
            if (o == SW) s.memw = 1;
            plan.push_back(s);
            if (o == LW) begin
                s = '0; s.rs = 2'b01; s.regw = 1;
                plan.push_back(s);
            end
        end else if (o == RT || o == IT) begin
            s = '0; s.sa = 2'b10; s.sb = (o == IT) ? 2'b01 : 2'b00;
            case (f3)
                3'b000:  s.op = (o == RT && f75) ? 3'b001 : 3'b000;
                3'b010:  s.op = 3'b101;
                3'b110:  s.op = 3'b010;
                3'b111:  s.op = 3'b011;
                default: begin s.op = 3'b000; s.ill = 1; end
            endcase
            plan.push_back(s);
            s = '0; s.regw = 1;
            plan.push_back(s);
        end else if (o == BQ) begin
            s = '0; s.sa = 2'b10; s.op = 3'b001; s.br = 1;
            plan.push_back(s);
        end else begin
            s = '0; s.sa = 2'b01; s.sb = 2'b10; s.pcu = 1;
            plan.push_back(s);
            s = '0; s.regw = 1;
            plan.push_back(s);
        end
    endtask

    function automatic logic [16:0] dut_word();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
                result_src, alu_src_a, alu_src_b, imm_src, alu_op};
    endfunction

    function automatic logic [16:0] ref_word(input step_t s, input logic in_reset);
        logic pcw;
        pcw = (s.pcu | (s.br & zero)) & ~in_reset;
        return {pcw, s.adr, s.memw & ~in_reset, s.irw & ~in_reset, s.regw & ~in_reset,
                s.ill & ~in_reset, s.rs, s.sa, s.sb, ref_imm(opcode), s.op};
    endfunction

    function automatic step_t fetch_step();
        step_t s;
        s = '0; s.irw = 1; s.pcu = 1; s.sb = 2'b10; s.rs = 2'b10;
        return s;
    endfunction

    task automatic test_reset();
        logic [16:0] exp_w, got;
        for (int i = 0; i < 4; i++) begin
            opcode = 7'($urandom); funct3 = 3'($urandom);
            funct7_5 = 1'($urandom); zero = 1'($urandom);
            @(negedge clk);
            exp_w = ref_word(fetch_step(), 1'b1);
            got   = dut_word();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got %h expected %h", i, got, exp_w);
            end
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [6:0] o;
        logic [2:0] f3;
        logic       f75;
        int         zmode;
    } instr_t;

    task automatic test_instructions();
        instr_t tbl[$];
        logic [6:0] ops[6] = '{LW, SW, RT, IT, BQ, JL};
        logic [16:0] exp_w, got;
        instr_t t;
        int n_steps;
        tbl.push_back('{LW, 3'b010, 1'b0, 2});
        tbl.push_back('{SW, 3'b010, 1'b0, 2});
        tbl.push_back('{RT, 3'b000, 1'b1, 2});
        tbl.push_back('{RT, 3'b010, 1'b0, 2});
        tbl.push_back('{RT, 3'b111, 1'b0, 2});
        tbl.push_back('{IT, 3'b000, 1'b1, 2});
        tbl.push_back('{BQ, 3'b000, 1'b0, 1});
        tbl.push_back('{BQ, 3'b000, 1'b0, 0});
        tbl.push_back('{7'b1111111, 3'b000, 1'b0, 2});
        tbl.push_back('{JL, 3'b000, 1'b0, 2});
        tbl.push_back('{RT, 3'b011, 1'b0, 2});
        for (int i = 0; i < 250; i++) begin
            t.o   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            t.f3  = 3'($urandom);
            t.f75 = 1'($urandom);
            t.zmode = 2;
            tbl.push_back(t);
        end
        foreach (tbl[k]) begin
            opcode = tbl[k].o; funct3 = tbl[k].f3; funct7_5 = tbl[k].f75;
            build_plan(tbl[k].o, tbl[k].f3, tbl[k].f75);
            n_steps = plan.size();
            for (int c = 0; c < n_steps; c++) begin
                zero = (tbl[k].zmode == 2) ? 1'($urandom) : tbl[k].zmode[0];
                @(negedge clk);
                exp_w = ref_word(plan[c], 1'b0);
                got   = dut_word();
                vectors++;
                if (got !== exp_w) begin
                    miscompares++;
                    $display("FAIL instr[%0d] op=%b f3=%b cycle %0d: got %h expected %h",
                             k, tbl[k].o, tbl[k].f3, c + 1, got, exp_w);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_instr();
        logic [16:0] exp_w, got;
        int n_steps;
        opcode = LW; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
        build_plan(LW, 3'b010, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        exp_w = ref_word(plan[3], 1'b0);
        got   = dut_word();
        vectors++;
        if (got !== exp_w) begin
            miscompares++;
            $display("FAIL mem_read_before_reset: got %h expected %h", got, exp_w);
        end
        #2 rst = 1'b1;
        #1;
        exp_w = ref_word(fetch_step(), 1'b1);
        got   = dut_word();
        vectors++;
        if (got !== exp_w) begin
            miscompares++;
            $display("FAIL async_reset_mid_read: got %h expected %h", got, exp_w);
        end
        @(posedge clk); #1;
        got = dut_word();
        vectors++;
        if (got !== exp_w || reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held_over_edge: got %h expected %h", got, exp_w);
        end
        rst = 1'b0;
        opcode = SW; funct3 = 3'b010;
        build_plan(SW, 3'b010, 1'b0);
        n_steps = plan.size();
        for (int c = 0; c < n_steps; c++) begin
            zero = 1'($urandom);
            @(negedge clk);
            exp_w = ref_word(plan[c], 1'b0);
            got   = dut_word();
            vectors++;
            if (got !== exp_w) begin
                miscompares++;
                $display("FAIL after_reset_sw cycle %0d: got %h expected %h", c + 1, got, exp_w);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0;
        test_reset();
        test_instructions();
        test_reset_mid_instr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
